// File: rtl/dma_controller.sv
// nano6502 block-copy DMA engine: CPU-programmed SRC/DST/LEN,
// halts the CPU via RDY and copies one byte every three cycles.
module dma_controller (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic        R_W_n,
  input  logic [3:0]  addr_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  input  logic [7:0]  mem_data_i,
  output logic        cpu_rdy_o,
  output logic        dma_gnt_o,
  output logic [15:0] dma_addr_o,
  output logic        dma_rw_n_o,
  output logic [7:0]  dma_data_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_RD,
    S_RDW,
    S_WR,
    S_END
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  // ctrl: [0] SRCINC, [1] DSTINC, [2] IRQEN
  logic [2:0]  ctrl_q, ctrl_d;
  logic        done_q, done_d;
  logic [7:0]  latch_q, latch_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        busy;
  logic        wr_en;
  logic [7:0]  rmux;

  assign busy  = (state_q != S_IDLE);
  assign wr_en = cs_i && !R_W_n;

  always_comb begin
    rmux = 8'h00;
    case (addr_i)
      4'd0: rmux = src_q[7:0];
      4'd1: rmux = src_q[15:8];
      4'd2: rmux = dst_q[7:0];
      4'd3: rmux = dst_q[15:8];
      4'd4: rmux = len_q[7:0];
      4'd5: rmux = len_q[15:8];
      4'd6: rmux = {4'b0, ctrl_q, 1'b0};
      4'd7: rmux = {6'b0, done_q, busy};
      default: rmux = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    ctrl_d  = ctrl_q;
    done_d  = done_q;
    latch_d = latch_q;
    rdata_d = rdata_q;

    if (cs_i && R_W_n)
      rdata_d = rmux;

    if (wr_en && addr_i == 4'd7)
      done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          case (addr_i)
            4'd0: src_d[7:0]  = data_i;
            4'd1: src_d[15:8] = data_i;
            4'd2: dst_d[7:0]  = data_i;
            4'd3: dst_d[15:8] = data_i;
            4'd4: len_d[7:0]  = data_i;
            4'd5: len_d[15:8] = data_i;
            4'd6: begin
              ctrl_d = data_i[3:1];
              if (data_i[0]) begin
                // empty copy completes immediately, no bus grab
                if (len_q == 16'h0000)
                  done_d = 1'b1;
                else begin
                  done_d  = 1'b0;
                  state_d = S_HALT;
                end
              end
            end
            default: ;
          endcase
        end
      end
      S_HALT: state_d = S_RD;
      S_RD:   state_d = S_RDW;
      S_RDW: begin
        latch_d = mem_data_i;
        state_d = S_WR;
      end
      S_WR: begin
        len_d   = len_q - 16'd1;
        src_d   = src_q + {15'b0, ctrl_q[0]};
        dst_d   = dst_q + {15'b0, ctrl_q[1]};
        state_d = (len_d != 16'h0000) ? S_RD : S_END;
      end
      S_END: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
      len_q   <= 16'h0000;
      ctrl_q  <= 3'b000;
      done_q  <= 1'b0;
      latch_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
      latch_q <= latch_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    cpu_rdy_o  = 1'b0;
    dma_gnt_o  = 1'b0;
    dma_addr_o = 16'h0000;
    dma_rw_n_o = 1'b1;
    dma_data_o = 8'h00;
    case (state_q)
      S_IDLE: cpu_rdy_o = 1'b1;
      S_RD, S_RDW: begin
        dma_gnt_o  = 1'b1;
        dma_addr_o = src_q;
      end
      S_WR: begin
        dma_gnt_o  = 1'b1;
        dma_addr_o = dst_q;
        dma_rw_n_o = 1'b0;
        dma_data_o = latch_q;
      end
      default: ;
    endcase
  end

  assign data_o = rdata_q;
  assign irq_o  = done_q & ctrl_q[2];

endmodule
